// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter/sequencer in front of a shared 8-bit ALU
//
// Purpose: accepts one operation at a time from port 0 (core datapath) or
// port 1 (auxiliary engine). It drives registered operands and a command onto
// the ALU for one execute cycle, captures the result, and holds it until the
// owning port accepts it.
//
// Ports:
//   clk, reset                 - rising-edge clock, asynchronous active-high reset
//   req{0,1}_valid/_ready      - request handshake; ready is the arbitration grant
//   req{0,1}_cmd/_a/_b         - ALU command and operands from each port
//   alu_cmd, alu_a, alu_b      - registered drive to the ALU
//   alu_rslt                   - ALU result, sampled in EXEC only
//   rsp_valid[1:0]             - one-hot response valid; the bit set is the owner
//   rsp_ready[1:0]             - per-port response accept
//   rsp_data                   - captured result
//   busy                       - state is not IDLE
//   gnt_cnt0, gnt_cnt1         - saturating accepted-operation counters
//
// Configuration: ALU_ARB_RR_EN selects round-robin arbitration when it is
// defined. When it is undefined, port 0 has fixed priority.

module alu_arbiter #(
  parameter int A    = 3,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [A:0]      req0_cmd,
  input  logic [7:0]      req0_a,
  input  logic [7:0]      req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [A:0]      req1_cmd,
  input  logic [7:0]      req1_a,
  input  logic [7:0]      req1_b,
  output logic [A:0]      alu_cmd,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_rslt,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [7:0]      rsp_data,
  output logic            busy,
  output logic [CNTW-1:0] gnt_cnt0,
  output logic [CNTW-1:0] gnt_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_next;
  logic   own;
  logic   grant0;
  logic   grant1;
  logic   accept;

`ifdef ALU_ARB_RR_EN
  // Names the port that wins when both ports are valid. 0 means port 0.
  logic   rr_ptr;
`endif

  // Grants exist only in IDLE. They are mutually exclusive by construction.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
`ifdef ALU_ARB_RR_EN
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
`else
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
`endif
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[own]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      own       <= 1'b0;
      alu_cmd   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 2'b00;
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      state <= state_next;
      // busy is loaded from the next state, so it tracks the state register exactly.
      busy  <= (state_next != IDLE);

      if (accept) begin
        alu_cmd <= grant1 ? req1_cmd : req0_cmd;
        alu_a   <= grant1 ? req1_a   : req0_a;
        alu_b   <= grant1 ? req1_b   : req0_b;
        own     <= grant1;
        if (grant0 && (gnt_cnt0 != CNT_MAX)) gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
        if (grant1 && (gnt_cnt1 != CNT_MAX)) gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
`ifdef ALU_ARB_RR_EN
        // Priority passes to the port that did not just win.
        rr_ptr  <= ~grant1;
`endif
      end

      if (state == EXEC) begin
        rsp_data  <= alu_rslt;
        rsp_valid <= own ? 2'b10 : 2'b01;
      end

      if ((state == RESP) && rsp_ready[own]) begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard testbench for alu_arbiter

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_cmd = '0, req1_cmd = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] alu_cmd;
  logic [7:0] alu_a, alu_b, alu_rslt;
  logic [1:0] rsp_valid;
  logic [1:0] rsp_ready = 2'b00;
  logic [7:0] rsp_data;
  logic       busy;
  logic [7:0] gnt_cnt0, gnt_cnt1;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.A(3), .CNTW(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
    .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_rslt(alu_rslt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Reference ALU: 0 and, 1 xor, 2 or, 3 add, 4 b<<a, 5 sub, others 0.
  function automatic logic [7:0] alu_model(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    case (cmd)
      4'h0:    return a & b;
      4'h1:    return a ^ b;
      4'h2:    return a | b;
      4'h3:    return a + b;
      4'h4:    return b << a[2:0];
      4'h5:    return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_rslt = alu_model(alu_cmd, alu_a, alu_b);

  task automatic reset_pulse();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (alu_cmd !== 4'h0) begin errors++; $display("FAIL reset_alu_cmd: got %h want 0", alu_cmd); end
    checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00) begin errors++; $display("FAIL reset_alu_ab: got %h/%h want 00/00", alu_a, alu_b); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (gnt_cnt0 !== 8'h00 || gnt_cnt1 !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h/%h want 00/00", gnt_cnt0, gnt_cnt1); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
  endtask

  task automatic test_single_add();
    exp_t e;
    @(posedge clk); #1;
    rsp_ready = 2'b11; req0_cmd = 4'b0011; req0_a = 8'h25; req0_b = 8'h1A; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL add_accept: got %b%b want 01", req1_ready, req0_ready); end
    if (req0_ready) begin e.port = 1'b0; e.data = 8'h3F; sb.push_back(e); end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (alu_cmd !== 4'h3 || alu_a !== 8'h25 || alu_b !== 8'h1A) begin errors++; $display("FAIL add_exec_drive: got %h %h %h want 3 25 1a", alu_cmd, alu_a, alu_b); end
    checks++; if (busy !== 1'b1 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_exec_state: busy %b rsp_valid %b want 1 00", busy, rsp_valid); end
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL add_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_data !== e.data) begin errors++; $display("FAIL add_rsp_data: got %h want %h", rsp_data, e.data); end
    end
    checks++; if (gnt_cnt0 !== 8'd1) begin errors++; $display("FAIL add_gnt_cnt0: got %0d want 1", gnt_cnt0); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL add_idle: busy %b rsp_valid %b want 0 00", busy, rsp_valid); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    @(posedge clk); #1;
    rsp_ready = 2'b00; req1_cmd = 4'b0001; req1_a = 8'hF0; req1_b = 8'h3C; req1_valid = 1'b1;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_accept: got %b%b want 10", req1_ready, req0_ready); end
    if (req1_ready) begin e.port = 1'b1; e.data = 8'hCC; sb.push_back(e); end
    // Port 0 requests meanwhile, and port 0's rsp_ready stays high: neither may matter.
    @(posedge clk); #1;
    req1_valid = 1'b0; req0_cmd = 4'h2; req0_a = 8'h01; req0_b = 8'h02; req0_valid = 1'b1; rsp_ready = 2'b01;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_ready: got %b want 0", req0_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 8'hCC) begin errors++; $display("FAIL bp_hold[%0d]: got %b %h want 10 cc", i, rsp_valid, rsp_data); end
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b%b want 00", i, req1_ready, req0_ready); end
    end
    @(posedge clk); #1 req0_valid = 1'b0; rsp_ready = 2'b10;
    @(negedge clk);
    if (sb.size() == 0) begin checks++; errors++; $display("FAIL bp_sb_empty: got 0 entries want 1"); end
    else begin
      e = sb.pop_front();
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== e.data) begin errors++; $display("FAIL bp_rsp: got %b %h want 10 %h", rsp_valid, rsp_data, e.data); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_idle: busy %b rsp_valid %b want 0 00", busy, rsp_valid); end
    checks++; if (gnt_cnt1 !== 8'd1) begin errors++; $display("FAIL bp_gnt_cnt1: got %0d want 1", gnt_cnt1); end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         grants = 0;
    int         cyc = 0;
    int         last_acc = -1;
    logic [3:0] order = 4'b0000;
    logic       saw1 = 1'b0;
`ifdef ALU_ARB_RR_EN
    logic [3:0] exp_order = 4'b1010;
    logic       exp_saw1 = 1'b1;
    logic [7:0] exp_c0 = 8'd2, exp_c1 = 8'd2;
`else
    logic [3:0] exp_order = 4'b0000;
    logic       exp_saw1 = 1'b0;
    logic [7:0] exp_c0 = 8'd4, exp_c1 = 8'd0;
`endif
    reset_pulse();
    rsp_ready = 2'b11;
    req0_cmd = 4'h3; req0_a = 8'h10; req0_b = 8'h01; req0_valid = 1'b1;
    req1_cmd = 4'hF; req1_a = 8'hAA; req1_b = 8'h55; req1_valid = 1'b1;
    while ((grants < 4 || sb.size() > 0) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      checks++; if (req0_ready && req1_ready) begin errors++; $display("FAIL b2b_exclusive: got 11 want at most one ready"); end
      if (req1_ready) saw1 = 1'b1;
      if (req0_ready || req1_ready) begin
        if (last_acc >= 0) begin
          checks++; if (cyc - last_acc != 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", cyc - last_acc); end
        end
        last_acc = cyc;
        order[grants] = req1_ready;
        e.port = req1_ready;
        e.data = req1_ready ? 8'h00 : 8'h11;
        sb.push_back(e);
        grants++;
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL b2b_unexpected_rsp: got %b want none", rsp_valid); end
        else begin
          e = sb.pop_front();
          checks++; if (rsp_valid !== (e.port ? 2'b10 : 2'b01) || rsp_data !== e.data) begin errors++; $display("FAIL b2b_rsp: got %b %h want port %0d %h", rsp_valid, rsp_data, e.port, e.data); end
        end
      end
      @(posedge clk); #1;
      if (grants == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (cyc >= 60) begin errors++; $display("FAIL b2b_timeout: got %0d grants want 4 and drained", grants); end
    checks++; if (order !== exp_order) begin errors++; $display("FAIL b2b_order: got %b want %b", order, exp_order); end
    checks++; if (saw1 !== exp_saw1) begin errors++; $display("FAIL b2b_req1_ready_seen: got %b want %b", saw1, exp_saw1); end
    checks++; if (gnt_cnt0 !== exp_c0 || gnt_cnt1 !== exp_c1) begin errors++; $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", gnt_cnt0, gnt_cnt1, exp_c0, exp_c1); end
  endtask

  task automatic test_reset_during_resp();
    exp_t e;
    int   nresp = 0;
    @(posedge clk); #1;
    rsp_ready = 2'b00; req0_cmd = 4'h3; req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rr_accept: got %b want 1", req0_ready); end
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rr_in_resp: got %b want 01", rsp_valid); end
    #2 reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rr_async_clear: rsp_valid %b busy %b want 00 0", rsp_valid, busy); end
    checks++; if (gnt_cnt0 !== 8'h00 || gnt_cnt1 !== 8'h00) begin errors++; $display("FAIL rr_cnt_clear: got %h/%h want 00/00", gnt_cnt0, gnt_cnt1); end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 2'b11; req0_cmd = 4'b0100; req0_a = 8'h02; req0_b = 8'h05; req0_valid = 1'b1;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rr_next_accept: got %b want 1", req0_ready); end
    if (req0_ready) begin e.port = 1'b0; e.data = 8'h14; sb.push_back(e); end
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (|(rsp_valid & rsp_ready)) begin
        nresp++;
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL rr_extra_rsp: got %b %h want none", rsp_valid, rsp_data); end
        else begin
          e = sb.pop_front();
          checks++; if (rsp_valid !== 2'b01 || rsp_data !== e.data) begin errors++; $display("FAIL rr_shift_rsp: got %b %h want 01 %h", rsp_valid, rsp_data, e.data); end
        end
      end
    end
    checks++; if (nresp != 1) begin errors++; $display("FAIL rr_rsp_count: got %0d want 1", nresp); end
  endtask

  task automatic test_saturation();
    exp_t       e;
    int         acc = 0;
    int         cyc = 0;
    logic [7:0] exp_cnt;
    reset_pulse();
    rsp_ready = 2'b11;
    req0_cmd = 4'h0; req0_a = 8'h5A; req0_b = 8'h0F; req0_valid = 1'b1;
    while ((acc < 260 || sb.size() > 0) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (req0_ready) begin
        acc++;
        // The counter shows the accepts before this one until the next edge.
        exp_cnt = (acc - 1 > 255) ? 8'hFF : 8'(acc - 1);
        checks++; if (gnt_cnt0 !== exp_cnt) begin errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", acc, gnt_cnt0, exp_cnt); end
        e.port = 1'b0; e.data = 8'h0A; sb.push_back(e);
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (sb.size() == 0) begin checks++; errors++; $display("FAIL sat_extra_rsp: got %b want none", rsp_valid); end
        else begin
          e = sb.pop_front();
          checks++; if (rsp_valid !== 2'b01 || rsp_data !== e.data) begin errors++; $display("FAIL sat_rsp: got %b %h want 01 %h", rsp_valid, rsp_data, e.data); end
        end
      end
      @(posedge clk); #1;
      if (acc == 260) req0_valid = 1'b0;
    end
    req0_valid = 1'b0;
    checks++; if (cyc >= 1000) begin errors++; $display("FAIL sat_timeout: got %0d accepts want 260", acc); end
    checks++; if (gnt_cnt0 !== 8'hFF) begin errors++; $display("FAIL sat_final_cnt0: got %h want ff", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 8'h00) begin errors++; $display("FAIL sat_final_cnt1: got %h want 00", gnt_cnt1); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_backpressure();
    test_back_to_back();
    test_reset_during_resp();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
